adc_scan_controller: RTL and testbench

Parametrised scan controller for the on-board ADC128S022 12-bit ADC. Generalises the fixed three-channel line-sensor reader: it scans a configurable ordered list of up to 8 channels, accounts for the converter's one-frame address pipeline, and publishes per-channel results with valid strobes. It sits between the frequency-scaling block that supplies `adc_clk` and the line-following and sensor logic.

---
 rtl/adc_scan_controller.sv | 111 +++++++++++
 tb/tb_adc_scan_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_controller.sv
// adc_scan_controller: scans an ordered channel list on an ADC128S022 and publishes per-slot results
// Ports: adc_clk (SCLK-rate clock, also the ADC SCLK), rst_n (synchronous active-low, sampled on both edges),
//   enable (level scan request), dout (ADC serial data) -> adc_cs_n (chip select), din (serial address),
//   ch_data (12 bits per slot), data_valid/data_slot (slot write strobe), scan_done (last slot written)
// Define ADC_SCAN_AVG_EN to publish the truncated mean of each slot's last 4 samples instead of the raw sample.
module adc_scan_controller #(
  parameter int NUM_CH = 3,
  parameter logic [23:0] CH_LIST = 24'o000_341
) (
  input  logic adc_clk,
  input  logic rst_n,
  input  logic enable,
  input  logic dout,
  output logic adc_cs_n,
  output logic din,
  output logic [12*NUM_CH-1:0] ch_data,
  output logic data_valid,
  output logic [2:0] data_slot,
  output logic scan_done
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state;
  logic [3:0] bit_cnt;
  logic [2:0] slot_ptr, pend_slot, slot_nxt, addr;
  logic hold, start, wr, last, din_nxt;
  logic [10:0] sh;
  logic [11:0] word;
  always_comb begin
    addr = state == DRAIN ? 3'd0 : CH_LIST[3*slot_ptr +: 3];
    slot_nxt = slot_ptr == 3'(NUM_CH-1) ? 3'd0 : slot_ptr + 3'd1;
    // after DRAIN, bit_cnt doubles as the 16-cycle chip-select-high gap counter
    start = enable && (!hold || bit_cnt == 4'd15);
    din_nxt = bit_cnt == 4'd1 ? addr[2] : bit_cnt == 4'd2 ? addr[1] : bit_cnt == 4'd3 ? addr[0] : 1'b0;
    word = {sh, dout};
    // PRIME returns the power-up channel-0 conversion, which belongs to no slot
    wr = (state == RUN || state == DRAIN) && bit_cnt == 4'd15;
    last = pend_slot == 3'(NUM_CH-1);
  end
  // frame control runs on negedge so din/cs_n are stable for the ADC's rising-edge sampling
  always_ff @(negedge adc_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= 4'd0;
      slot_ptr <= 3'd0;
      pend_slot <= 3'd0;
      hold <= 1'b0;
      adc_cs_n <= 1'b1;
      din <= 1'b0;
    end else if (state == IDLE) begin
      state <= start ? PRIME : IDLE;
      adc_cs_n <= !start;
      din <= 1'b0;
      bit_cnt <= (start || !hold) ? 4'd0 : bit_cnt + 4'd1;
      hold <= hold && bit_cnt != 4'd15;
      slot_ptr <= 3'd0;
      pend_slot <= 3'd0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
      din <= din_nxt;
      if (bit_cnt == 4'd15) begin
        state <= state == PRIME ? RUN : state == RUN ? (enable ? RUN : DRAIN) : IDLE;
        adc_cs_n <= state == DRAIN;
        hold <= state == DRAIN;
        // the address sent this frame selects the data returned next frame
        pend_slot <= slot_ptr;
        slot_ptr <= slot_nxt;
      end
    end
  end
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      sh <= '0;
      data_valid <= 1'b0;
      data_slot <= 3'd0;
      scan_done <= 1'b0;
    end else begin
      if (state != IDLE && bit_cnt >= 4'd4 && bit_cnt <= 4'd14) sh <= {sh[9:0], dout};
      data_valid <= wr;
      scan_done <= wr && last;
      if (wr) data_slot <= pend_slot;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    logic [11:0] q;
    logic hit;
    assign hit = wr && pend_slot == 3'(i);
    assign ch_data[12*i +: 12] = q;
`ifdef ADC_SCAN_AVG_EN
    logic [3:0][11:0] h;
    logic [13:0] sum, sum_nxt;
    // running sum: drop the oldest sample, add the new one
    assign sum_nxt = sum - {2'b00, h[3]} + {2'b00, word};
    always_ff @(posedge adc_clk) begin
      if (!rst_n) begin
        h <= '0;
        sum <= '0;
        q <= '0;
      end else if (hit) begin
        h <= {h[2:0], word};
        sum <= sum_nxt;
        q <= sum_nxt[13:2];
      end
    end
`else
    always_ff @(posedge adc_clk) begin
      if (!rst_n) q <= '0;
      else if (hit) q <= word;
    end
`endif
  end
endmodule

// File: tb/tb_adc_scan_controller.sv
// tb_adc_scan_controller: self-checking bench for adc_scan_controller (3-slot, 1-slot and 8-slot instances)
module tb_adc_scan_controller;
  localparam logic [2:0][3:0] NCH = {4'd8, 4'd1, 4'd3};
  localparam logic [2:0][23:0] CHL = {24'o01234567, 24'o00000007, 24'o00000341};
  typedef struct {
    logic [11:0] v1, v4, v3;
    logic [35:0] exp;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [2:0] en, cs_n, din, dv, sd;
  logic [2:0][2:0] slot;
  logic [2:0][95:0] chd;
  int passed = 0, total = 0;
  logic [11:0] chv [8];
  logic [11:0] seq [6] = '{12'd4000, 12'd4000, 12'd0, 12'd0, 12'd2000, 12'd2000};
  int addr_log [$];
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wait_done(input int g, input int k);
    int n = 0, t = 0;
    while (n < k && t < 150 * k + 100) begin
      @(posedge clk); #1; t++;
      if (sd[g]) n++;
    end
    check($sformatf("scan_done_wait%0d", g), 96'(n), 96'(k));
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int N = int'(NCH[g]);
    localparam logic [23:0] L = CHL[g];
    logic d = 1'b0;
    logic [12*N-1:0] cd;
    logic [12*N-1:0] shadow = '0;
    logic [11:0] word = '0, ev, ex;
    logic [2:0] nxt = '0, cur = '0;
    logic [14:0] e;
    int bitn = 15, r = -1, fc = 0, dvn = 0, dinbad = 0, s;
    logic [14:0] exq [$];
`ifdef ADC_SCAN_AVG_EN
    logic [3:0][11:0] hist [8];
`endif
    adc_scan_controller #(.NUM_CH(N), .CH_LIST(L)) u_dut (
      .adc_clk(clk), .rst_n(rst_n), .enable(en[g]), .dout(d), .adc_cs_n(cs_n[g]), .din(din[g]),
      .ch_data(cd), .data_valid(dv[g]), .data_slot(slot[g]), .scan_done(sd[g])
    );
    assign chd[g] = 96'(cd);
    function automatic logic [11:0] val(input logic [2:0] ch, input int rr, input int f);
      if (g == 0) return chv[ch];
      if (g == 1) return rr < 1 ? 12'hABC : seq[rr > 6 ? 5 : rr - 1];
      return f[0] ? 12'hFFF : 12'h000;
    endfunction
    // ADC model: address latched in frame k selects the conversion returned in frame k+1
    always @(negedge clk) begin
      #1;
`ifdef ADC_SCAN_AVG_EN
      if (!rst_n) for (int k = 0; k < 8; k++) hist[k] = '0;
`endif
      if (cs_n[g]) begin
        bitn = 15; r = -1; d = 1'b0;
      end else begin
        bitn = (bitn + 1) % 16;
        if (bitn == 0) begin
          r++; fc++;
          cur = nxt;
          word = val(cur, r, fc);
          if (r > 0) begin
            s = (r - 1) % N;
            ev = val(L[3*s +: 3], r, fc);
`ifdef ADC_SCAN_AVG_EN
            hist[s] = {hist[s][2:0], ev};
            ex = 12'((int'(hist[s][0]) + int'(hist[s][1]) + int'(hist[s][2]) + int'(hist[s][3])) / 4);
`else
            ex = ev;
`endif
            exq.push_back({3'(s), ex});
          end
        end
        d = bitn >= 4 ? word[15 - bitn] : 1'b0;
      end
    end
    always @(posedge clk) begin
      if (!cs_n[g] && bitn >= 2 && bitn <= 4) begin
        nxt = {nxt[1:0], din[g]};
        if (g == 0 && bitn == 4) addr_log.push_back(int'(nxt));
      end else if (din[g]) dinbad++;
    end
    always @(posedge clk) begin
      #1;
      if (!rst_n) begin
        exq.delete();
        shadow = '0;
      end else if (dv[g]) begin
        dvn++;
        if (exq.size() == 0) check($sformatf("unexpected_valid%0d", g), 96'(1), 96'(0));
        else begin
          e = exq.pop_front();
          shadow[12*e[14:12] +: 12] = e[11:0];
          check($sformatf("data_slot%0d", g), 96'(slot[g]), 96'(e[14:12]));
          check($sformatf("ch_data%0d", g), 96'(cd), 96'(shadow));
          check($sformatf("scan_done%0d", g), 96'(sd[g]), 96'(e[14:12] == 3'(N-1)));
        end
      end else if (sd[g]) check($sformatf("done_without_valid%0d", g), 96'(1), 96'(0));
    end
  end
  initial begin
    vec_t tbl [4];
    int exp_addr [4];
    int t, n;
    tbl[0] = '{12'd100, 12'd400, 12'd300, {12'd300, 12'd400, 12'd100}};
    tbl[1] = '{12'hFFF, 12'h000, 12'hFFF, {12'hFFF, 12'h000, 12'hFFF}};
    tbl[2] = '{12'h000, 12'hFFF, 12'h5A5, {12'h5A5, 12'hFFF, 12'h000}};
    tbl[3] = '{12'h123, 12'h456, 12'h789, {12'h789, 12'h456, 12'h123}};
    exp_addr = '{1, 4, 3, 1};
    for (int c = 0; c < 8; c++) chv[c] = 12'(c * 100);
    chv[0] = 12'hABC;
    rst_n = 1'b0;
    en = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 96'(cs_n), 96'(3'b111));
    check("rst_din", 96'(din), 96'(0));
    check("rst_valid", 96'(dv), 96'(0));
    check("rst_done", 96'(sd), 96'(0));
    check("rst_slot", 96'(slot), 96'(0));
    for (int k = 0; k < 3; k++) check($sformatf("rst_ch_data%0d", k), chd[k], 96'(0));
    rst_n = 1'b1;
    en[0] = 1'b1;
    t = 0;
    while (cs_n[0] && t < 50) begin @(negedge clk); #1; t++; end
    check("prime_start", 96'(cs_n[0]), 96'(0));
    n = 0;
    while (!dv[0] && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 31) check("prime_discard", chd[0], 96'(0));
    end
    check("first_valid_latency", 96'(n), 96'(32));
    wait_done(0, 1);
    check("addr_log_len", 96'(addr_log.size() >= 4), 96'(1));
    for (int k = 0; k < 4 && k < addr_log.size(); k++) check($sformatf("din_addr%0d", k), 96'(addr_log[k]), 96'(exp_addr[k]));
    for (int i = 0; i < 4; i++) begin
      chv[1] = tbl[i].v1;
      chv[4] = tbl[i].v4;
      chv[3] = tbl[i].v3;
      wait_done(0, 4);
      check($sformatf("table_row%0d", i), 96'(chd[0][35:0]), 96'(tbl[i].exp));
    end
    t = 0;
    do begin @(negedge clk); #1; t++; end while (g_i[0].bitn != 7 && t < 40);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("midrst_cs_n", 96'(cs_n[0]), 96'(1));
    check("midrst_din", 96'(din[0]), 96'(0));
    check("midrst_ch_data", chd[0], 96'(0));
    check("midrst_valid", 96'(dv[0]), 96'(0));
    check("midrst_slot", 96'(slot[0]), 96'(0));
    check("midrst_done", 96'(sd[0]), 96'(0));
    en[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    en[1] = 1'b1;
    t = 0;
    while (!(g_i[1].r == 5 && g_i[1].bitn == 9) && t < 200) begin @(negedge clk); #1; t++; end
    check("b_frame5_bit9", 96'(t < 200), 96'(1));
    en[1] = 1'b0;
    t = 0;
    while (!cs_n[1] && t < 60) begin @(negedge clk); #1; t++; end
    check("b_cs_rise", 96'(cs_n[1]), 96'(1));
    check("b_results", 96'(g_i[1].dvn), 96'(6));
    en[1] = 1'b1;
    t = 0;
    while (cs_n[1] && t < 40) begin @(negedge clk); #1; t++; end
    check("b_idle_gap", 96'(t >= 16 && t < 40), 96'(1));
    en[1] = 1'b0;
    t = 0;
    while (!cs_n[1] && t < 80) begin @(negedge clk); #1; t++; end
    check("b_cs_rise2", 96'(cs_n[1]), 96'(1));
    repeat (40) @(posedge clk);
    #1;
    check("b_results2", 96'(g_i[1].dvn), 96'(8));
    check("b_cs_idle", 96'(cs_n[1]), 96'(1));
    en[2] = 1'b1;
    wait_done(2, 3);
    en[2] = 1'b0;
    t = 0;
    while (!cs_n[2] && t < 80) begin @(negedge clk); #1; t++; end
    check("c_cs_rise", 96'(cs_n[2]), 96'(1));
    repeat (20) @(posedge clk);
    #1;
    check("din_idle0", 96'(g_i[0].dinbad), 96'(0));
    check("din_idle1", 96'(g_i[1].dinbad), 96'(0));
    check("din_idle2", 96'(g_i[2].dinbad), 96'(0));
    check("sb_empty1", 96'(g_i[1].exq.size()), 96'(0));
    check("sb_empty2", 96'(g_i[2].exq.size()), 96'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
